// File: rtl/qspi_flash_rd_seq.sv
// Quad-SPI flash read sequencer: issues one Fast Read Quad I/O (0xEB) transaction
// per accepted request and returns a little-endian 32-bit word with a valid pulse.
module qspi_flash_rd_seq #(
    parameter int DUMMY_CYC = 4,
    parameter int CS_IDLE   = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_i,
    input  logic [23:0] addr_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        fsclk,
    output logic        fcen,
    output logic [3:0]  fdo,
    output logic        fdoe,
    input  logic [3:0]  fdi
);

    localparam logic [7:0] CMD_QIO    = 8'hEB;
    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYC - 1);
    localparam logic [3:0] CS_LAST    = 4'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_DONE
    } state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        phase, phase_d;
    logic [23:0] addr_q;
    logic [27:0] shift_q;

    logic        accept;
    logic        data_end;
    logic        fcen_d, fsclk_d, fdoe_d, ready_d;
    logic [3:0]  fdo_d;

    function automatic logic [3:0] last_sck(input state_t s);
        case (s)
            S_CMD:   return 4'd7;
            S_ADDR:  return 4'd5;
            S_MODE:  return 4'd1;
            S_DUMMY: return DUMMY_LAST;
            default: return 4'd7;
        endcase
    endfunction

    function automatic logic [3:0] addr_nibble(input logic [23:0] a, input logic [3:0] idx);
        case (idx)
            4'd0:    return a[23:20];
            4'd1:    return a[19:16];
            4'd2:    return a[15:12];
            4'd3:    return a[11:8];
            4'd4:    return a[7:4];
            default: return a[3:0];
        endcase
    endfunction

    // Nibbles arrive byte-serial, high nibble first; first byte lands in the low lane.
    function automatic logic [31:0] le_word(input logic [31:0] s);
        return {s[7:0], s[15:8], s[23:16], s[31:24]};
    endfunction

    assign accept   = req_i & ready_o;
    assign data_end = (state == S_DATA) & phase & (cnt == 4'd7);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            phase <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            phase <= phase_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        phase_d = phase;
        case (state)
            S_IDLE: begin
                if (accept) state_d = S_START;
            end
            S_START: begin
                state_d = S_CMD;
                cnt_d   = 4'd0;
                phase_d = 1'b0;
            end
            S_DONE: begin
                if (cnt == CS_LAST) state_d = S_IDLE;
                else                cnt_d   = cnt + 4'd1;
            end
            default: begin
                if (!phase) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (cnt == last_sck(state)) begin
                        cnt_d = 4'd0;
                        case (state)
                            S_CMD:   state_d = S_ADDR;
                            S_ADDR:  state_d = S_MODE;
                            S_MODE:  state_d = S_DUMMY;
                            S_DUMMY: state_d = S_DATA;
                            default: begin
                                // The edge that ends the last SCK already counts as one CS-idle cycle.
                                state_d = (CS_IDLE == 1) ? S_IDLE : S_DONE;
                                cnt_d   = 4'd1;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end
            end
        endcase
    end

    // Pin values are decoded from the next state so every output is a plain flop.
    always_comb begin
        fcen_d  = !(state_d inside {S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA});
        fsclk_d = !fcen_d & phase_d;
        fdoe_d  = state_d inside {S_CMD, S_ADDR, S_MODE};
        ready_d = (state_d == S_IDLE);
        fdo_d   = 4'h0;
        case (state_d)
            S_CMD:   fdo_d = {3'b110, CMD_QIO[3'd7 - cnt_d[2:0]]};
            S_ADDR:  fdo_d = addr_nibble(addr_q, cnt_d);
            default: fdo_d = 4'h0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fcen     <= 1'b1;
            fsclk    <= 1'b0;
            fdoe     <= 1'b0;
            fdo      <= 4'h0;
            ready_o  <= 1'b0;
            rvalid_o <= 1'b0;
            rdata_o  <= 32'h0;
        end else begin
            fcen     <= fcen_d;
            fsclk    <= fsclk_d;
            fdoe     <= fdoe_d;
            fdo      <= fdo_d;
            ready_o  <= ready_d;
            rvalid_o <= data_end;
            if (data_end) rdata_o <= le_word({shift_q, fdi});
        end
    end

    always_ff @(posedge HCLK) begin
        if (state == S_IDLE && accept) addr_q <= addr_i;
        if (state == S_DATA && phase)  shift_q <= {shift_q[23:0], fdi};
    end

endmodule

// File: tb/tb_qspi_flash_rd_seq.sv
// Bench for qspi_flash_rd_seq: two builds (DUMMY_CYC 4 and 8) each wired to a
// pin-level flash model that decodes the command and address and returns data.
module tb_qspi_flash_rd_seq;

    localparam int D0 = 4;
    localparam int D1 = 8;

    logic        HCLK = 1'b0;
    logic        rst_n;
    logic        req[2];
    logic [23:0] addr[2];
    logic        ready[2];
    logic        rvalid[2];
    logic [31:0] rdata[2];
    logic        fsclk[2];
    logic        fcen[2];
    logic [3:0]  fdo[2];
    logic        fdoe[2];
    logic [3:0]  fdi[2] = '{4'h0, 4'h0};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          acc_n[2]    = '{0, 0};
    int          acc_cyc[2]  = '{0, 0};
    int          rv_n[2]     = '{0, 0};
    int          rv_cyc[2]   = '{0, 0};
    int          gap[2]      = '{0, 0};
    int          hi_run[2]   = '{0, 0};
    int          viol[2]     = '{0, 0};
    int          falls[2]    = '{0, 0};
    int          rises[2]    = '{0, 0};
    int          oe_err[2]   = '{0, 0};
    int          hold_err[2] = '{0, 0};
    logic [31:0] rv_data[2];
    logic [7:0]  cap_cmd[2];
    logic [23:0] cap_adr[2];
    logic [7:0]  cap_mode[2];
    logic        prev_sclk[2] = '{1'b0, 1'b0};
    logic        prev_fcen[2] = '{1'b1, 1'b1};

    qspi_flash_rd_seq u_dut0 (
        .HCLK(HCLK), .HRESETn(rst_n), .req_i(req[0]), .addr_i(addr[0]),
        .ready_o(ready[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
        .fsclk(fsclk[0]), .fcen(fcen[0]), .fdo(fdo[0]), .fdoe(fdoe[0]), .fdi(fdi[0])
    );

    qspi_flash_rd_seq #(.DUMMY_CYC(D1), .CS_IDLE(2)) u_dut1 (
        .HCLK(HCLK), .HRESETn(rst_n), .req_i(req[1]), .addr_i(addr[1]),
        .ready_o(ready[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
        .fsclk(fsclk[1]), .fcen(fcen[1]), .fdo(fdo[1]), .fdoe(fdoe[1]), .fdi(fdi[1])
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    // Flash contents: a few known bytes at 0x100, a position-dependent pattern elsewhere.
    function automatic logic [7:0] mem(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = mem(a + 24'(b));
        return w;
    endfunction

    // Pin monitor and flash model, evaluated mid-cycle where all DUT outputs are stable.
    always @(negedge HCLK) begin
        for (int i = 0; i < 2; i++) begin
            int dn, r, d;
            logic [7:0] bv;
            dn = (i == 0) ? D0 : D1;
            if (rst_n && req[i] && ready[i]) begin
                acc_n[i]++;
                acc_cyc[i] = cyc + 1;
            end
            if (rvalid[i]) begin
                rv_n[i]++;
                rv_cyc[i]  = cyc;
                rv_data[i] = rdata[i];
            end
            if (fcen[i]) hi_run[i]++;
            else if (hi_run[i] > 0) begin
                gap[i]    = hi_run[i];
                hi_run[i] = 0;
            end
            if (fcen[i] && fsclk[i]) viol[i]++;
            if (!fcen[i] && prev_fcen[i]) begin
                falls[i]++;
                rises[i]    = 0;
                cap_cmd[i]  = 8'h0;
                cap_adr[i]  = 24'h0;
                cap_mode[i] = 8'h0;
                oe_err[i]   = 0;
                hold_err[i] = 0;
            end
            if (!fcen[i] && fsclk[i] && !prev_sclk[i]) begin
                r = rises[i];
                if (fdoe[i] !== (r < 16)) oe_err[i]++;
                if (r >= 16 && fdo[i] !== 4'h0) oe_err[i]++;
                if (r < 8) begin
                    cap_cmd[i] = {cap_cmd[i][6:0], fdo[i][0]};
                    if (fdo[i][3:1] !== 3'b110) hold_err[i]++;
                end else if (r < 14) begin
                    cap_adr[i] = {cap_adr[i][19:0], fdo[i]};
                end else if (r < 16) begin
                    cap_mode[i] = {cap_mode[i][3:0], fdo[i]};
                end else if (r >= 16 + dn && r < 24 + dn) begin
                    d  = r - 16 - dn;
                    bv = mem(cap_adr[i] + 24'(d / 2));
                    fdi[i] = (d % 2 == 0) ? bv[7:4] : bv[3:0];
                end
                rises[i]++;
            end
            prev_sclk[i] = fsclk[i];
            prev_fcen[i] = fcen[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #2;
    endtask

    // Raises req with the given address and returns just after the accepting edge.
    task automatic start_read(input int i, input logic [23:0] a);
        int n0;
        n0      = acc_n[i];
        req[i]  = 1'b1;
        addr[i] = a;
        for (int t = 0; t < 300 && acc_n[i] == n0; t++) step(1);
        check($sformatf("accept%0d", i), acc_n[i] - n0, 1);
    endtask

    task automatic wait_rv(input int i, input int n0);
        for (int t = 0; t < 300 && rv_n[i] == n0; t++) step(1);
        check($sformatf("rvalid_seen%0d", i), rv_n[i] - n0, 1);
    endtask

    task automatic do_read(input int i, input logic [23:0] a, input string tag);
        int n0, f0, dn;
        logic [31:0] ev;
        dn = (i == 0) ? D0 : D1;
        ev = exp_word(a);
        n0 = rv_n[i];
        f0 = falls[i];
        start_read(i, a);
        req[i]  = 1'b0;
        addr[i] = 24'($urandom);
        wait_rv(i, n0);
        check({tag, ".data"}, rv_data[i], ev);
        check({tag, ".latency"}, rv_cyc[i] - acc_cyc[i], 1 + 2 * (24 + dn));
        step(3);
        check({tag, ".pulses"}, rv_n[i] - n0, 1);
        check({tag, ".hold"}, rdata[i], ev);
        check({tag, ".cmd"}, cap_cmd[i], 8'hEB);
        check({tag, ".addr"}, cap_adr[i], a);
        check({tag, ".mode"}, cap_mode[i], 8'h00);
        check({tag, ".sck"}, rises[i], 24 + dn);
        check({tag, ".oe"}, oe_err[i], 0);
        check({tag, ".cmd_io"}, hold_err[i], 0);
        check({tag, ".cs_lows"}, falls[i] - f0, 1);
    endtask

    initial begin
        int n0, f0, a0, acc1, nrv;
        logic [23:0] ra, rb;

        rst_n   = 1'b0;
        req[0]  = 1'b0;
        req[1]  = 1'b0;
        addr[0] = 24'h0;
        addr[1] = 24'h0;
        step(3);
        for (int i = 0; i < 2; i++) begin
            check("rst.fcen", fcen[i], 1);
            check("rst.fsclk", fsclk[i], 0);
            check("rst.fdoe", fdoe[i], 0);
            check("rst.fdo", fdo[i], 0);
            check("rst.rvalid", rvalid[i], 0);
            check("rst.rdata", rdata[i], 0);
        end
        rst_n = 1'b1;
        step(1);
        check("rst.ready0", ready[0], 1);
        check("rst.ready1", ready[1], 1);

        do_read(0, 24'h000100, "rd100");
        check("rd100.word", rv_data[0], 32'h44332211);

        // req held high across two transactions
        n0 = rv_n[0];
        f0 = falls[0];
        start_read(0, 24'h000000);
        acc1    = acc_cyc[0];
        addr[0] = 24'h000004;
        wait_rv(0, n0);
        check("b2b.data0", rv_data[0], exp_word(24'h000000));
        start_read(0, 24'h000004);
        req[0] = 1'b0;
        check("b2b.accept_gap", acc_cyc[0] - acc1, 59);
        step(1);
        check("b2b.cs_high_ge2", gap[0] >= 2, 1);
        wait_rv(0, n0 + 1);
        check("b2b.data1", rv_data[0], exp_word(24'h000004));
        check("b2b.cs_lows", falls[0] - f0, 2);
        step(3);

        // Reset pulled in the middle of DATA
        start_read(0, 24'($urandom));
        req[0] = 1'b0;
        step(50);
        nrv   = rv_n[0];
        rst_n = 1'b0;
        #1;
        check("midrst.fcen", fcen[0], 1);
        check("midrst.fsclk", fsclk[0], 0);
        check("midrst.fdoe", fdoe[0], 0);
        check("midrst.rvalid", rvalid[0], 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        check("midrst.ready", ready[0], 1);
        step(70);
        check("midrst.no_rvalid", rv_n[0] - nrv, 0);
        do_read(0, 24'($urandom), "post_rst");

        // Request pulsed while busy is dropped
        ra = 24'h00ABC0;
        rb = 24'h123450;
        n0 = rv_n[0];
        f0 = falls[0];
        a0 = acc_n[0];
        start_read(0, ra);
        req[0] = 1'b0;
        step(20);
        req[0]  = 1'b1;
        addr[0] = rb;
        step(1);
        req[0] = 1'b0;
        wait_rv(0, n0);
        check("busy_req.data", rv_data[0], exp_word(ra));
        step(8);
        check("busy_req.accepts", acc_n[0] - a0, 1);
        check("busy_req.cs_lows", falls[0] - f0, 1);

        do_read(0, 24'hFFFFFE, "wrap");
        do_read(1, 24'hFFFFFC, "d8top");

        for (int k = 0; k < 6; k++) do_read(0, 24'($urandom), $sformatf("rnd0_%0d", k));
        for (int k = 0; k < 3; k++) do_read(1, 24'($urandom), $sformatf("rnd1_%0d", k));

        check("sclk_while_cs_high0", viol[0], 0);
        check("sclk_while_cs_high1", viol[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
